if_fetch_queue: RTL and testbench

Parametrised successor of the single-entry IF/ID pipeline register. It is a DEPTH-entry FIFO of {pc, instruction} pairs between the fetch stage and the decode stage. Fetch can run ahead while decode is frozen. A flush discards all in-flight instructions on a taken branch. Whenever the queue is empty, the decode stage receives a zero (NOP) bubble.

---
 rtl/if_fetch_queue.sv | 114 +++++++++++
 tb/tb_if_fetch_queue.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// ---------------------------------------------------------------------------
// if_fetch_queue
//
// DEPTH-entry FIFO of {pc, instruction} pairs between fetch and decode.
// Fetch can run ahead while decode is frozen. A flush drops everything in
// flight, for example on a taken branch. When the queue is empty, decode sees
// an all-zero NOP bubble.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous reset, active-high
//   flush         synchronous clear of all entries; beats push, pop, freeze
//   freeze        decode stall; the head entry is not consumed
//   push_valid    fetch presents a valid pc/instruction pair
//   pcIn          fetched pc (pc+4 from fetch)
//   instructionIn fetched instruction word
//   push_ready    queue can accept a push this cycle (~full)
//   almost_full   count >= AF_LEVEL
//   out_valid     head entry is valid (~empty)
//   pcOut         head pc, 0 when out_valid=0
//   instruction   head instruction, 0 when out_valid=0
//   count         current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module if_fetch_queue #(
    parameter int N        = 32,
    parameter int DEPTH    = 4,   // power of two, >= 2
    parameter int AF_LEVEL = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       freeze,
    input  logic                       push_valid,
    input  logic [N-1:0]               pcIn,
    input  logic [N-1:0]               instructionIn,
    output logic                       push_ready,
    output logic                       almost_full,
    output logic                       out_valid,
    output logic [N-1:0]               pcOut,
    output logic [N-1:0]               instruction,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_COUNT   = CW'(AF_LEVEL);

    logic [N-1:0]  pc_mem    [DEPTH];
    logic [N-1:0]  instr_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          do_push;
    logic          do_pop;

    assign full        = (count == FULL_COUNT);
    assign empty       = (count == '0);
    assign push_ready  = ~full;
    assign out_valid   = ~empty;
    assign almost_full = (count >= AF_COUNT);

    // A full queue ignores push_valid even when a pop frees a slot on the same
    // edge. This keeps push_ready purely a function of the registered count.
    assign do_push = push_valid & push_ready & ~flush;
    assign do_pop  = out_valid & ~freeze & ~flush;

    // NOTE: state registers use non-blocking assignments. Every flop then
    // samples the pre-edge values, whatever order the blocks run in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // The pointers wrap for free because DEPTH is a power of two.
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset. The pointers and count define
    // which entries are live, so stale data is never observable. Leaving the
    // array unreset also lets it map onto plain RAM or flops without reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            pc_mem[wr_ptr]    <= pcIn;
            instr_mem[wr_ptr] <= instructionIn;
        end
    end

    // NOTE: both outputs get a default before the if. No path leaves them
    // unassigned, so no latch is inferred. The default is also the NOP bubble.
    always_comb begin
        pcOut       = '0;
        instruction = '0;
        if (out_valid) begin
            pcOut       = pc_mem[rd_ptr];
            instruction = instr_mem[rd_ptr];
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_queue
//
// Scoreboard bench for if_fetch_queue. The driver changes inputs 1 time unit
// after each rising edge. On every falling edge the monitor compares the DUT
// outputs against an ordered queue of expected {pc, instruction} pairs. It
// then applies the queue rules to that queue for the inputs that will be seen
// at the next rising edge.
// ---------------------------------------------------------------------------
module tb_if_fetch_queue;

    localparam int N     = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [N-1:0] pc;
        logic [N-1:0] ins;
    } entry_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          freeze = 1'b0;
    logic          push_valid = 1'b0;
    logic [N-1:0]  pcIn = '0;
    logic [N-1:0]  instructionIn = '0;
    logic          push_ready;
    logic          almost_full;
    logic          out_valid;
    logic [N-1:0]  pcOut;
    logic [N-1:0]  instruction;
    logic [CW-1:0] count;

    int     n_compared   = 0;
    int     n_mismatched = 0;
    entry_t exp_q[$];

    if_fetch_queue #(.N(N), .DEPTH(DEPTH), .AF_LEVEL(DEPTH - 1)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .freeze        (freeze),
        .push_valid    (push_valid),
        .pcIn          (pcIn),
        .instructionIn (instructionIn),
        .push_ready    (push_ready),
        .almost_full   (almost_full),
        .out_valid     (out_valid),
        .pcOut         (pcOut),
        .instruction   (instruction),
        .count         (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor and scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            check("rst_out_valid", 64'(out_valid), 64'd0);
            check("rst_pcOut", 64'(pcOut), 64'd0);
            check("rst_instr", 64'(instruction), 64'd0);
            check("rst_count", 64'(count), 64'd0);
            check("rst_push_ready", 64'(push_ready), 64'd1);
        end else begin
            check("count", 64'(count), 64'(exp_q.size()));
            check("push_ready", 64'(push_ready), 64'(exp_q.size() < DEPTH));
            check("almost_full", 64'(almost_full), 64'(exp_q.size() >= DEPTH - 1));
            check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                check("head_pc", 64'(pcOut), 64'(exp_q[0].pc));
                check("head_instr", 64'(instruction), 64'(exp_q[0].ins));
            end else begin
                check("bubble_pc", 64'(pcOut), 64'd0);
                check("bubble_instr", 64'(instruction), 64'd0);
            end
            // Reference rules for the coming edge. A push is judged against
            // the occupancy before any pop on that edge.
            if (flush) begin
                exp_q.delete();
            end else begin
                automatic bit can_push = push_valid && (exp_q.size() < DEPTH);
                if (exp_q.size() != 0 && !freeze) void'(exp_q.pop_front());
                if (can_push) exp_q.push_back('{pc: pcIn, ins: instructionIn});
            end
        end
    end

    // Sets the inputs for one cycle, then advances to just after the edge.
    task automatic cyc(input bit pv, input logic [N-1:0] pc, input logic [N-1:0] ins,
                       input bit frz, input bit fl);
        push_valid    = pv;
        pcIn          = pc;
        instructionIn = ins;
        freeze        = frz;
        flush         = fl;
        @(posedge clk);
        #1;
    endtask

    // Holds a pair on the push side until it is accepted. The wait is bounded.
    task automatic push_hold(input logic [N-1:0] pc, input logic [N-1:0] ins, input bit frz);
        bit done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            done = push_ready;
            cyc(1'b1, pc, ins, frz, 1'b0);
        end
        if (!done) check("push_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;

        // Fill under freeze, then attempt a fifth push that must be ignored.
        for (int i = 0; i < 4; i++) cyc(1'b1, N'(4 * (i + 1)), N'(32'hA0 + i), 1'b1, 1'b0);
        cyc(1'b1, N'(20), N'(32'hA4), 1'b1, 1'b0);
        cyc(1'b1, N'(20), N'(32'hA4), 1'b1, 1'b0);

        // Drain while pushing 20, 24, 28. The pointers wrap past entry 3.
        for (int i = 0; i < 3; i++) push_hold(N'(20 + 4 * i), N'(32'hA4 + i), 1'b0);
        idle(6);

        // Flush priority: count=2, then flush with freeze and a push of pc 40.
        cyc(1'b1, N'(32), N'(32'hB0), 1'b1, 1'b0);
        cyc(1'b1, N'(36), N'(32'hB1), 1'b1, 1'b0);
        cyc(1'b1, N'(40), N'(32'hB2), 1'b1, 1'b1);
        idle(1);

        // Simultaneous push and pop at count=1.
        cyc(1'b1, N'(96), N'(32'hC0), 1'b0, 1'b0);
        cyc(1'b1, N'(100), N'(32'hC1), 1'b0, 1'b0);
        idle(2);

        // Empty bubble for 3 cycles, then one push.
        idle(3);
        cyc(1'b1, N'(200), N'(32'hD0), 1'b0, 1'b0);
        idle(3);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom_range(0, 99) < 60), N'($urandom) & ~N'(3), N'($urandom),
                1'($urandom_range(0, 99) < 40), 1'($urandom_range(0, 99) < 4));
        end

        // Asynchronous reset mid-run with count=3, checked before the next edge.
        cyc(1'b0, '0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b1, N'(300 + 4 * i), N'(32'hE0 + i), 1'b1, 1'b0);
        push_valid = 1'b0;
        check("pre_rst_count", 64'(count), 64'd3);
        #1 rst = 1'b1;
        #1;
        check("async_rst_count", 64'(count), 64'd0);
        check("async_rst_out_valid", 64'(out_valid), 64'd0);
        check("async_rst_pcOut", 64'(pcOut), 64'd0);
        check("async_rst_instr", 64'(instruction), 64'd0);
        check("async_rst_push_ready", 64'(push_ready), 64'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(2);
        cyc(1'b1, N'(400), N'(32'hF0), 1'b0, 1'b0);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
